// File: rtl/idi_bus_mst_arb.sv
// -----------------------------------------------------------------------------
// idi_bus_mst_arb
//
// Multi-channel IDI register-bus master. Up to NUM_CH requesters present
// read/write commands on a valid/ready handshake. A round-robin arbiter picks
// one channel while idle, the command is latched, and a single IDI transfer is
// driven until the slave acks or the optional timeout aborts it. The result
// goes back to the granted channel as a one-cycle response pulse.
//
// FSM
//   state    | meaning
//   ST_IDLE  | no transfer in flight; arbitrate and accept one command
//   ST_REQ   | idi_req_o held, waiting for idi_ack_i or timeout
//   ST_RSP   | one-cycle response to the granted channel
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   ch_req_vld_i    per-channel command valid
//   ch_req_rdy_o    per-channel accept (one-hot or zero, combinational)
//   ch_req_wr_i     per-channel direction, 1 = write
//   ch_req_addr_i   packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_req_wdata_i  packed write data, channel i at [i*DATA_W +: DATA_W]
//   ch_rsp_vld_o    per-channel one-cycle response pulse
//   ch_rsp_rdata_o  shared response data, valid with ch_rsp_vld_o
//   ch_rsp_err_o    shared response error, valid with ch_rsp_vld_o
//   idi_req_o       bus request
//   idi_wr_o        bus direction
//   idi_addr_o      bus address
//   idi_wdata_o     bus write data
//   idi_ack_i       slave completion
//   idi_rdata_i     slave read data, sampled with idi_ack_i
//   idi_err_i       slave error, sampled with idi_ack_i
//   busy_o          transfer or response in progress
//   to_pulse_o      one-cycle pulse, high in the response cycle of an abort
// -----------------------------------------------------------------------------
module idi_bus_mst_arb #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [NUM_CH-1:0]        ch_req_vld_i,
    output logic [NUM_CH-1:0]        ch_req_rdy_o,
    input  logic [NUM_CH-1:0]        ch_req_wr_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_req_wdata_i,

    output logic [NUM_CH-1:0]        ch_rsp_vld_o,
    output logic [DATA_W-1:0]        ch_rsp_rdata_o,
    output logic                     ch_rsp_err_o,

    output logic                     idi_req_o,
    output logic                     idi_wr_o,
    output logic [ADDR_W-1:0]        idi_addr_o,
    output logic [DATA_W-1:0]        idi_wdata_o,
    input  logic                     idi_ack_i,
    input  logic [DATA_W-1:0]        idi_rdata_i,
    input  logic                     idi_err_i,

    output logic                     busy_o,
    output logic                     to_pulse_o
);

    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_EN ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     gnt_q, gnt_d;
    logic                cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                to_pulse_q, to_pulse_d;

    // -------------------------------------------------------------------------
    // Round-robin arbiter: search upward starting one past the last grant.
    // gnt_q resets to the last channel so channel 0 wins the first round.
    // -------------------------------------------------------------------------
    logic                arb_found;
    logic [CH_W-1:0]     arb_idx;
    logic [CH_W-1:0]     arb_cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            arb_cand = CH_W'((int'(gnt_q) + i) % NUM_CH);
            if (!arb_found && ch_req_vld_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    always_comb begin
        sel_wr    = ch_req_wr_i[arb_idx];
        sel_addr  = ch_req_addr_i[int'(arb_idx) * ADDR_W +: ADDR_W];
        sel_wdata = ch_req_wdata_i[int'(arb_idx) * DATA_W +: DATA_W];
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        cmd_wr_d     = cmd_wr_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
        to_pulse_d   = 1'b0;
        ch_req_rdy_o = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // rdy is suppressed during reset so no requester believes a
                // command was taken on an edge that is about to be discarded.
                if (arb_found && !rst_i) begin
                    ch_req_rdy_o[arb_idx] = 1'b1;
                    gnt_d                 = arb_idx;
                    cmd_wr_d              = sel_wr;
                    cmd_addr_d            = sel_addr;
                    cmd_wdata_d           = sel_wdata;
                    state_d               = ST_REQ;
                end
            end

            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A late ack on the final timeout cycle still completes
                // normally; the abort path is only taken without an ack.
                if (idi_ack_i) begin
                    rsp_rdata_d = cmd_wr_q ? '0 : idi_rdata_i;
                    rsp_err_d   = idi_err_i;
                    state_d     = ST_RSP;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    to_pulse_d  = 1'b1;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= LAST_CH;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            to_pulse_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            to_pulse_q  <= to_pulse_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: bus side straight from the latched command, response side
    // gated to the RSP cycle so the shared data bus reads as 0 otherwise.
    // -------------------------------------------------------------------------
    logic in_rsp;
    assign in_rsp = (state_q == ST_RSP);

    always_comb begin
        ch_rsp_vld_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rsp_vld_o[i] = in_rsp && (gnt_q == CH_W'(i));
        end
    end

    assign ch_rsp_rdata_o = in_rsp ? rsp_rdata_q : '0;
    assign ch_rsp_err_o   = in_rsp & rsp_err_q;

    assign idi_req_o   = (state_q == ST_REQ);
    assign idi_wr_o    = cmd_wr_q;
    assign idi_addr_o  = cmd_addr_q;
    assign idi_wdata_o = cmd_wdata_q;

    assign busy_o      = (state_q != ST_IDLE);
    assign to_pulse_o  = to_pulse_q;

endmodule

// File: tb/tb_idi_bus_mst_arb.sv
module tb_idi_bus_mst_arb;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TO_W    = 8;
    localparam int TIMEOUT = 200;

    logic                     clk;
    logic                     rst;

    logic [NUM_CH-1:0]        vld;
    logic [NUM_CH-1:0]        rdy;
    logic [NUM_CH-1:0]        t_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        rsp_vld;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     idi_req;
    logic                     idi_wr;
    logic [ADDR_W-1:0]        idi_addr;
    logic [DATA_W-1:0]        idi_wdata;
    logic                     idi_ack;
    logic [DATA_W-1:0]        idi_rdata;
    logic                     idi_err;
    logic                     busy;
    logic                     to_pulse;

    logic [ADDR_W-1:0]        t_addr  [NUM_CH];
    logic [DATA_W-1:0]        t_wdata [NUM_CH];

    // single-channel, timeout-disabled instance
    logic                     n_vld, n_rdy, n_wr, n_rsp_vld, n_rsp_err;
    logic [ADDR_W-1:0]        n_addr, n_iaddr;
    logic [DATA_W-1:0]        n_wdata, n_rsp_rdata, n_iwdata, n_irdata;
    logic                     n_req, n_iwr, n_ack, n_ierr, n_busy, n_to;

    int vectors    = 0;
    int miscompares = 0;
    int last_g     = NUM_CH - 1;

    always_comb begin
        ch_addr  = '0;
        ch_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr[i*ADDR_W +: ADDR_W]  = t_addr[i];
            ch_wdata[i*DATA_W +: DATA_W] = t_wdata[i];
        end
    end

    idi_bus_mst_arb #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .ch_req_vld_i(vld), .ch_req_rdy_o(rdy), .ch_req_wr_i(t_wr),
        .ch_req_addr_i(ch_addr), .ch_req_wdata_i(ch_wdata),
        .ch_rsp_vld_o(rsp_vld), .ch_rsp_rdata_o(rsp_rdata), .ch_rsp_err_o(rsp_err),
        .idi_req_o(idi_req), .idi_wr_o(idi_wr), .idi_addr_o(idi_addr), .idi_wdata_o(idi_wdata),
        .idi_ack_i(idi_ack), .idi_rdata_i(idi_rdata), .idi_err_i(idi_err),
        .busy_o(busy), .to_pulse_o(to_pulse)
    );

    idi_bus_mst_arb #(
        .NUM_CH(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_W(TO_W), .TIMEOUT(0)
    ) u_dut_nt (
        .clk_i(clk), .rst_i(rst),
        .ch_req_vld_i(n_vld), .ch_req_rdy_o(n_rdy), .ch_req_wr_i(n_wr),
        .ch_req_addr_i(n_addr), .ch_req_wdata_i(n_wdata),
        .ch_rsp_vld_o(n_rsp_vld), .ch_rsp_rdata_o(n_rsp_rdata), .ch_rsp_err_o(n_rsp_err),
        .idi_req_o(n_req), .idi_wr_o(n_iwr), .idi_addr_o(n_iaddr), .idi_wdata_o(n_iwdata),
        .idi_ack_i(n_ack), .idi_rdata_i(n_irdata), .idi_err_i(n_ierr),
        .busy_o(n_busy), .to_pulse_o(n_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requesting channel after the last grant.
    function automatic int rr_pick(input logic [NUM_CH-1:0] mask, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (mask[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
        end
        return 0;
    endfunction

    task automatic rand_cmds();
        for (int i = 0; i < NUM_CH; i++) begin
            t_addr[i]  = ADDR_W'($urandom);
            t_wdata[i] = $urandom;
            t_wr[i]    = 1'($urandom);
        end
    endtask

    // One complete transaction. ack_at < 0 means the slave never acks.
    task automatic txn(input logic [NUM_CH-1:0] mask, input int ack_at,
                       input logic [DATA_W-1:0] s_rdata, input logic s_err, input string tag);
        int                g, len;
        bit                timed;
        logic              e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata, e_rd;
        logic              e_err;

        g   = rr_pick(mask, last_g);
        vld = mask;
        #1;
        chk({tag, ".rdy"},  64'(rdy),  64'(1 << g));
        chk({tag, ".idle"}, 64'(busy), 64'(0));
        e_wr    = t_wr[g];
        e_addr  = t_addr[g];
        e_wdata = t_wdata[g];
        step();
        last_g = g;
        // disturb the channel inputs: the bus must keep the latched command
        t_addr[g]  = ~e_addr;
        t_wdata[g] = ~e_wdata;
        t_wr[g]    = ~e_wr;

        timed = (ack_at < 0) || (ack_at >= TIMEOUT);
        len   = timed ? TIMEOUT : ack_at + 1;
        for (int n = 0; n < len; n++) begin
            chk({tag, ".req"}, 64'(idi_req), 64'(1));
            chk({tag, ".cmd"}, {15'd0, idi_wr, idi_addr, idi_wdata}, {15'd0, e_wr, e_addr, e_wdata});
            if (!timed && n == ack_at) begin
                idi_ack   = 1'b1;
                idi_rdata = s_rdata;
                idi_err   = s_err;
            end
            step();
            idi_ack   = 1'b0;
            idi_rdata = $urandom;
            idi_err   = 1'($urandom);
        end

        e_rd  = (timed || e_wr) ? '0 : s_rdata;
        e_err = timed ? 1'b1 : s_err;
        chk({tag, ".rsp_vld"}, 64'(rsp_vld),   64'(1 << g));
        chk({tag, ".rdata"},   64'(rsp_rdata), 64'(e_rd));
        chk({tag, ".err"},     64'(rsp_err),   64'(e_err));
        chk({tag, ".to"},      64'(to_pulse),  64'(timed));
        chk({tag, ".req_lo"},  64'(idi_req),   64'(0));
        chk({tag, ".busy"},    64'(busy),      64'(1));
        step();
        chk({tag, ".end"}, {62'd0, busy, to_pulse}, 64'(0));
        chk({tag, ".rsp_end"}, 64'(rsp_vld), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rdy"},   64'(rdy),       64'(0));
        chk({tag, ".rsp"},   {27'd0, rsp_vld, rsp_err, rsp_rdata}, 64'(0));
        chk({tag, ".bus"},   {15'd0, idi_req, idi_addr, idi_wdata}, 64'(0));
        chk({tag, ".misc"},  {61'd0, idi_wr, busy, to_pulse}, 64'(0));
    endtask

    initial begin
        int hi, to_cnt;
        logic [DATA_W-1:0] n_exp;

        rst       = 1'b1;
        vld       = '0;
        t_wr      = '0;
        idi_ack   = 1'b0;
        idi_rdata = '0;
        idi_err   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        n_vld = 1'b0; n_wr = 1'b0; n_addr = '0; n_wdata = '0;
        n_ack = 1'b0; n_irdata = '0; n_ierr = 1'b0;

        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // single read, ch0, two wait cycles
        t_addr[0] = 16'h0010;
        t_wr[0]   = 1'b0;
        txn(4'b0001, 2, 32'hDEADBEEF, 1'b0, "rd_ch0");

        // single write, ch2, zero wait; read data must be suppressed
        t_addr[2]  = 16'h1234;
        t_wdata[2] = 32'hA5A5A5A5;
        t_wr[2]    = 1'b1;
        txn(4'b0100, 0, 32'hFFFFFFFF, 1'b0, "wr_ch2");

        // all channels continuously valid after reset: 0,1,2,3,0,...
        vld = '0;
        rst = 1'b1;
        step();
        rst    = 1'b0;
        last_g = NUM_CH - 1;
        rand_cmds();
        for (int i = 0; i < 8; i++) begin
            txn(4'b1111, int'($urandom_range(0, 3)), $urandom, 1'($urandom), "rr_all");
            chk("rr_order", 64'(last_g), 64'(i % NUM_CH));
        end

        // ack outside REQ is ignored
        vld     = '0;
        idi_ack = 1'b1;
        step();
        step();
        chk("ack_idle", {60'd0, busy, idi_req, rsp_err, to_pulse}, 64'(0));
        chk("ack_idle.rsp", 64'(rsp_vld), 64'(0));
        idi_ack = 1'b0;
        step();

        // timeout abort, then the next requester is served
        rand_cmds();
        txn(4'b0010, -1, $urandom, 1'b0, "timeout");
        txn(4'b1010, 0, $urandom, 1'b0, "after_to");
        chk("after_to.ch", 64'(last_g), 64'(3));

        // ack on the final timeout cycle wins over the abort
        rand_cmds();
        t_wr = '0;
        txn(4'($urandom_range(1, 15)), TIMEOUT - 1, $urandom, 1'b1, "late_ack");

        // randomized traffic
        for (int i = 0; i < 12; i++) begin
            rand_cmds();
            txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 5)), $urandom, 1'($urandom), "rand");
        end

        // reset while in REQ
        rand_cmds();
        vld = 4'b1111;
        step();
        step();
        step();
        chk("mid_rst.pre", 64'(idi_req), 64'(1));
        rst = 1'b1;
        step();
        chk_reset_outputs("mid_rst");
        rst    = 1'b0;
        last_g = NUM_CH - 1;
        txn(4'b1111, 1, $urandom, 1'b0, "post_rst");
        chk("post_rst.ch", 64'(last_g), 64'(0));
        vld = '0;

        // single channel, timeout disabled, 1000-cycle ack delay
        n_addr  = 16'hBEEF;
        n_wdata = $urandom;
        n_wr    = 1'b0;
        n_exp   = $urandom;
        n_vld   = 1'b1;
        #1;
        chk("nt.rdy", 64'(n_rdy), 64'(1));
        step();
        n_vld  = 1'b0;
        hi     = 0;
        to_cnt = 0;
        for (int n = 0; n <= 1000; n++) begin
            if (n_req) hi++;
            if (n_to) to_cnt++;
            if (n == 1000) begin
                n_ack    = 1'b1;
                n_irdata = n_exp;
            end
            step();
            n_ack = 1'b0;
        end
        chk("nt.req_cycles", 64'(hi), 64'(1001));
        chk("nt.no_to", 64'(to_cnt + int'(n_to)), 64'(0));
        chk("nt.rsp", {30'd0, n_rsp_vld, n_rsp_err, n_rsp_rdata}, {30'd0, 1'b1, 1'b0, n_exp});
        chk("nt.addr", 64'(n_iaddr), 64'(16'hBEEF));
        chk("nt.req_lo", 64'(n_req), 64'(0));
        step();
        chk("nt.idle", {62'd0, n_busy, n_rsp_vld}, 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/idi_bus_mst_arb.md
Name: idi_bus_mst_arb

Overview:
- N-channel IDI bus master.
- Accepts register read/write commands from NUM_CH independent requesters (valid/ready), arbitrates round-robin, and drives one IDI bus transfer at a time with an ack timeout.
- Returns a per-channel response pulse carrying read data and an error flag.
- Sits between on-chip config/DMA agents and the IDI register bus; the IDI VIP env drives its bus side in block-level simulation.

Parameters:
NUM_CH, 4, number of requester channels (1..16)
ADDR_W, 16, IDI address width
DATA_W, 32, IDI data width
TO_W, 8, timeout counter width
TIMEOUT, 200, cycles idi_req may wait for idi_ack before abort; 0 disables timeout; must be < 2**TO_W

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
ch_req_vld  in  NUM_CH  per-channel command valid
ch_req_rdy  out  NUM_CH  per-channel accept; one-hot or zero
ch_req_wr  in  NUM_CH  1=write, 0=read
ch_req_addr  in  NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
ch_req_wdata  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
ch_rsp_vld  out  NUM_CH  one-cycle response pulse to granted channel
ch_rsp_rdata  out  DATA_W  shared response data, valid with ch_rsp_vld
ch_rsp_err  out  1  shared error flag, valid with ch_rsp_vld
idi_req  out  1  bus request, held until ack or timeout
idi_wr  out  1  bus direction
idi_addr  out  ADDR_W  bus address
idi_wdata  out  DATA_W  bus write data
idi_ack  in  1  slave completion
idi_rdata  in  DATA_W  slave read data, sampled with idi_ack
idi_err  in  1  slave error, sampled with idi_ack
busy  out  1  FSM not in IDLE
to_pulse  out  1  one-cycle pulse on timeout abort

Behaviour:
Reset (rst=1 at a clk edge):
- All outputs 0.
- FSM=IDLE, timeout counter=0.
- RR pointer set so channel 0 has highest priority on the first arbitration.
- Reset mid-transfer drops idi_req the next cycle; no response is issued for the aborted command.

FSM states: IDLE, REQ, RSP.
- IDLE: if any ch_req_vld, grant the first set bit searching from (last_grant+1) mod NUM_CH upward.
  - Assert ch_req_rdy[g] combinationally in that cycle.
  - At the clock edge latch wr/addr/wdata of channel g, store g as last_grant, go to REQ.
  - Nothing pending: stay in IDLE, ch_req_rdy=0.
- REQ: idi_req=1; idi_wr/idi_addr/idi_wdata stable from the latched command for the whole state. Counter increments each REQ cycle.
  - idi_ack=1: latch rdata (forced 0 for writes) and err=idi_err, go to RSP.
  - No ack and counter==TIMEOUT-1 (TIMEOUT≠0): latch rdata=0, err=1, pulse to_pulse, go to RSP.
  - idi_ack and timeout in the same cycle: ack wins, no to_pulse.
- RSP: ch_rsp_vld[g]=1 for exactly one cycle with ch_rsp_rdata/ch_rsp_err. idi_req=0. Counter cleared. Go to IDLE. No response backpressure.

Timing:
- Accept at cycle 0 → idi_req high at cycle 1.
- Ack at cycle k → idi_req low and ch_rsp_vld high at cycle k+1.
- Earliest next accept at cycle k+2; bus throughput is 1 transfer per 3 cycles at zero-wait ack.

Rules:
- idi_ack outside REQ is ignored.
- A channel may deassert ch_req_vld before grant without effect.
- A channel whose vld is low at arbitration is skipped.
- The RR pointer advances only on a grant.
- busy=1 in REQ and RSP.
- NUM_CH=1 degenerates to a single-channel master with the same timing.

Test Plan:
- Single read, ch0, addr 0x0010, ack after 2 wait cycles with rdata 0xDEADBEEF → ch_req_rdy[0] cycle 0, idi_req cycles 1-3, ch_rsp_vld[0] cycle 4 with rdata 0xDEADBEEF, err 0.
- Single write, ch2, addr 0x1234, wdata 0xA5A5A5A5, zero-wait ack with idi_rdata 0xFFFFFFFF → idi_wr=1 and idi_wdata held, ch_rsp_vld[2] with rdata 0, err 0.
- All 4 channels valid continuously after reset → grant order 0,1,2,3,0,…; each ch_rsp_vld one cycle; no channel granted twice before the others.
- TIMEOUT=200, slave never acks → idi_req high exactly 200 cycles, to_pulse once, ch_rsp_vld with err 1 and rdata 0; the next channel is then granted.
- Ack on the last timeout cycle with idi_err=1 → response err 1 from the slave, to_pulse stays 0; TIMEOUT=0 with a 1000-cycle ack delay completes normally.
- rst asserted while in REQ → idi_req, busy and all rsp outputs 0 next cycle; channel 0 is granted first after reset release.
